dff_chain_loader: RTL and testbench
===================================

# dff_chain_loader

Serial-load controller for a chain of edge-triggered D flip-flops. It accepts a parallel word over a valid/ready handshake and shifts it LSB-first into an external WIDTH-stage DFF shift chain, one bit per cycle with a shift enable. It then issues a single-cycle LOAD strobe so downstream logic can capture the chain. It keeps a mirror of the last fully loaded word for readback, and sits between the register-programming logic and the flip-flop chain it configures.

## Interface

Parameters:
- WIDTH, default 8: number of DFF stages in the chain and the data word width. Legal range is WIDTH >= 2.

Ports:
- CLK  input  1  rising-edge clock for all state.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  the requester has a word on IN_DATA.
- IN_READY  output  1  the controller can accept a word.
- IN_DATA  input  WIDTH  parallel word to load.
- ABORT  input  1  cancels an in-progress shift.
- SER_D  output  1  serial data bit to chain stage 0.
- SER_EN  output  1  shift enable for the chain; the chain advances on CLK edges where SER_EN=1.
- LOAD  output  1  one-cycle capture strobe after a complete shift.
- BUSY  output  1  high whenever the state is not IDLE.
- PAR_Q  output  WIDTH  mirror of the last word completed with LOAD.

## Operation

- State machine: IDLE, SHIFT, LATCH.
- Internal registers:
  - shreg, WIDTH bits.
  - cnt, $clog2(WIDTH+1) bits.
  - PAR_Q.
- IDLE:
  - IN_READY = ~RST.
  - SER_EN=0, LOAD=0.
  - On IN_VALID & IN_READY: shreg <= IN_DATA, cnt <= 0, go to SHIFT.
- SHIFT:
  - SER_EN=1 and SER_D=shreg[0].
  - Each edge: shreg <= shreg >> 1 (zero-fill MSB), cnt <= cnt+1.
  - When cnt==WIDTH-1 at an edge (the last bit has been presented), go to LATCH.
- LATCH:
  - LOAD=1, SER_EN=0.
  - At the edge: PAR_Q <= the word captured at acceptance (held in a separate hold register), go to IDLE.
- ABORT:
  - Sampled only in SHIFT.
  - If ABORT=1 at an edge in SHIFT, go to IDLE; LOAD does not fire and PAR_Q is unchanged.
  - The chain is left partially shifted. Software must reload it.
  - ABORT in IDLE or LATCH is ignored; LATCH always completes.
- SER_D=0 whenever SER_EN=0.
- IN_READY is low in SHIFT and LATCH. A word held on IN_VALID while busy stays pending and is accepted in the next IDLE cycle.
- Reset:
  - RST=1 at an edge forces state=IDLE, shreg=0, cnt=0, PAR_Q=0.
  - RST has priority over ABORT and the handshake.
  - Reset in the middle of a shift drops the word without a LOAD.
- While RST=1: IN_READY=0.
- After reset: SER_D=0, SER_EN=0, LOAD=0, BUSY=0, PAR_Q=0, IN_READY=1 once RST=0.

## Timing

- SER_D, SER_EN, LOAD and BUSY are decoded from registered state with no input-to-output combinational path. IN_READY depends only on state and RST.
- For a handshake accepted at edge T:
  - SER_EN=1 in cycles T+1 through T+WIDTH.
  - In cycle T+k, SER_D = IN_DATA[k-1].
  - LOAD=1 in cycle T+WIDTH+1 only.
  - PAR_Q = IN_DATA from cycle T+WIDTH+2.
  - IN_READY=1 again from cycle T+WIDTH+2.
- Throughput: one word per WIDTH+2 cycles when IN_VALID is held high.
- ABORT sampled at edge T+j (1 <= j <= WIDTH) ends SHIFT: SER_EN=0 from cycle T+j+1, and exactly j bits have been shifted.
- The counter never wraps. The SHIFT exit is taken at cnt==WIDTH-1, so cnt never exceeds WIDTH-1.

## Test plan

- Reset then idle: hold RST=1 for 2 cycles, then release.
  - During reset: IN_READY=0, PAR_Q=0, SER_EN=0, LOAD=0.
  - Cycle after release: IN_READY=1, BUSY=0.
- Single load, WIDTH=8, IN_DATA=8'hA5 accepted at T:
  - SER_D over T+1..T+8 = 1,0,1,0,0,1,0,1 with SER_EN=1.
  - LOAD=1 only at T+9.
  - PAR_Q=8'hA5 and IN_READY=1 at T+10.
- Back-to-back: IN_VALID held with 8'h3C then 8'hFF.
  - The second handshake occurs exactly at T+10.
  - IN_READY stays low through T+9.
  - PAR_Q=8'h3C at T+10 and 8'hFF at T+20.
- Abort: load 8'h0F, pulse ABORT at edge T+3.
  - SER_EN low from T+4, no LOAD pulse.
  - PAR_Q keeps its previous value.
  - IN_READY=1 at T+4.
- Reset during shift: load 8'h81, assert RST at edge T+5.
  - All outputs reach reset values the next cycle.
  - No LOAD pulse, PAR_Q=0.
  - A following load of 8'h55 completes normally.
- Reference-model check: drive the SER_D/SER_EN stream into a behavioural 8-stage shift chain. On each LOAD, the chain contents equal PAR_Q in the next cycle, across 200 random words with random ABORTs.

Source files
------------

// File: rtl/dff_chain_loader.sv
// Serial-load controller: accepts a parallel word, shifts it LSB-first into an
// external DFF chain with a shift enable, then pulses LOAD and mirrors the word.
module dff_chain_loader #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             ABORT,
  output logic             SER_D,
  output logic             SER_EN,
  output logic             LOAD,
  output logic             BUSY,
  output logic [WIDTH-1:0] PAR_Q
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_d_q, ser_d_d;
  logic             ser_en_q, ser_en_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             accept;

  // Handshake: a word transfers on any rising edge where IN_VALID and IN_READY
  // are both high; IN_READY depends only on state and RST, never on IN_VALID.
  assign IN_READY = (state_q == IDLE) && !RST;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    hold_d  = hold_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = IN_DATA;
          hold_d  = IN_DATA;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        // Abort wins even on the final bit, so no LOAD follows a cancelled shift.
        if (ABORT) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        par_d   = hold_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    ser_en_d = (state_d == SHIFT);
    ser_d_d  = ser_en_d & shreg_d[0];
    load_d   = (state_d == LATCH);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      hold_q   <= '0;
      par_q    <= '0;
      cnt_q    <= '0;
      ser_d_q  <= 1'b0;
      ser_en_q <= 1'b0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      hold_q   <= hold_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      ser_d_q  <= ser_d_d;
      ser_en_q <= ser_en_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
    end
  end

  assign SER_D  = ser_d_q;
  assign SER_EN = ser_en_q;
  assign LOAD   = load_q;
  assign BUSY   = busy_q;
  assign PAR_Q  = par_q;

endmodule

// File: tb/tb_dff_chain_loader.sv
// Bench for dff_chain_loader: directed timing cases plus random words with
// random aborts, scored against a serial-bit queue and a behavioural chain.
module tb_dff_chain_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         abort;
  logic         ser_d;
  logic         ser_en;
  logic         load;
  logic         busy;
  logic [W-1:0] par_q;

  int total = 0;
  int bad   = 0;

  logic         bit_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] chain = '0;
  logic [W-1:0] pend_par = '0;
  bit           par_chk = 1'b0;
  logic [W-1:0] last_full = '0;

  dff_chain_loader #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .ABORT(abort), .SER_D(ser_d), .SER_EN(ser_en),
    .LOAD(load), .BUSY(busy), .PAR_Q(par_q)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(w[i]);
  endtask

  // Returns one step after the accepting edge (i.e. inside cycle T+1).
  task automatic accept(input logic [W-1:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_bit("accept_ready", in_ready, 1'b1);
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_bit("idle_reached", busy, 1'b0);
    step();
  endtask

  task automatic run_abort(input logic [W-1:0] w, input int j);
    accept(w);
    in_valid = 1'b0;
    abort    = 1'b0;
    push_bits(w, j);
    repeat (j - 1) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check_bit("abort_ser_en", ser_en, 1'b0);
    check_bit("abort_in_ready", in_ready, 1'b1);
    check_word("abort_par_q", par_q, last_full);
    step();
  endtask

  // monitor / scoreboard: behavioural chain fed from SER_D on enabled edges
  always @(negedge clk) begin
    if (!rst) begin
      if (par_chk) begin
        check_word("par_q_after_load", par_q, pend_par);
        check_word("chain_eq_par_q", chain, par_q);
        par_chk = 1'b0;
      end
      if (ser_en) begin
        if (bit_q.size() == 0) check_bit("ser_en_unexpected", ser_en, 1'b0);
        else check_bit("ser_d", ser_d, bit_q.pop_front());
        chain = {ser_d, chain[W-1:1]};
      end else begin
        check_bit("ser_d_idle", ser_d, 1'b0);
      end
      if (load) begin
        if (exp_q.size() == 0) begin
          check_bit("load_unexpected", load, 1'b0);
        end else begin
          pend_par = exp_q.pop_front();
          check_word("chain_at_load", chain, pend_par);
          par_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    int j;
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = '0;

    // reset then idle
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_word("rst_par_q", par_q, '0);
      check_bit("rst_ser_en", ser_en, 1'b0);
      check_bit("rst_load", load, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    check_bit("post_rst_in_ready", in_ready, 1'b1);
    check_bit("post_rst_busy", busy, 1'b0);
    check_bit("post_rst_ser_d", ser_d, 1'b0);
    step();

    // single load of A5
    accept(8'hA5);
    in_valid = 1'b0;
    push_bits(8'hA5, W);
    exp_q.push_back(8'hA5);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check_bit("single_ser_en", ser_en, 1'b1);
      check_bit("single_no_load", load, 1'b0);
      check_bit("single_busy", busy, 1'b1);
      step();
    end
    @(negedge clk);
    check_bit("single_load", load, 1'b1);
    check_bit("single_latch_ser_en", ser_en, 1'b0);
    check_bit("single_latch_ready", in_ready, 1'b0);
    step();
    @(negedge clk);
    check_bit("single_load_once", load, 1'b0);
    check_word("single_par_q", par_q, 8'hA5);
    check_bit("single_ready_back", in_ready, 1'b1);
    last_full = 8'hA5;
    step();

    // back-to-back 3C then FF with IN_VALID held
    accept(8'h3C);
    in_data = 8'hFF;
    push_bits(8'h3C, W);
    exp_q.push_back(8'h3C);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      check_bit("b2b_ready_low", in_ready, 1'b0);
      step();
    end
    @(negedge clk);
    check_bit("b2b_ready_high", in_ready, 1'b1);
    check_word("b2b_par_first", par_q, 8'h3C);
    step();
    in_valid = 1'b0;
    push_bits(8'hFF, W);
    exp_q.push_back(8'hFF);
    repeat (W + 1) step();
    @(negedge clk);
    check_word("b2b_par_second", par_q, 8'hFF);
    last_full = 8'hFF;
    step();

    // abort of 0F at edge T+3
    run_abort(8'h0F, 3);
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      check_bit("abort_no_load", load, 1'b0);
      step();
    end

    // reset during shift of 81, then a normal load of 55
    accept(8'h81);
    in_valid = 1'b0;
    push_bits(8'h81, 4);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_bit("midrst_ser_en", ser_en, 1'b0);
    check_bit("midrst_load", load, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check_word("midrst_par_q", par_q, '0);
    last_full = '0;
    step();
    accept(8'h55);
    in_valid = 1'b0;
    push_bits(8'h55, W);
    exp_q.push_back(8'h55);
    wait_idle();
    @(negedge clk);
    check_word("after_rst_par_q", par_q, 8'h55);
    last_full = 8'h55;
    step();

    // random words with random aborts, including on the final bit
    for (int it = 0; it < 200; it++) begin
      w = W'($urandom);
      j = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      wait_idle();
      repeat ($urandom_range(0, 2)) begin
        abort = 1'($urandom_range(0, 1));
        step();
      end
      if (j != 0) begin
        run_abort(w, j);
      end else begin
        abort = 1'($urandom_range(0, 1));
        accept(w);
        in_valid = 1'b0;
        abort    = 1'b0;
        push_bits(w, W);
        exp_q.push_back(w);
        last_full = w;
        if ($urandom_range(0, 3) == 0) begin
          repeat (W) step();
          abort = 1'b1;
          step();
          abort = 1'b0;
        end
      end
    end

    wait_idle();
    repeat (3) step();
    check_word("exp_q_drained", W'(exp_q.size()), '0);
    check_word("bit_q_drained", W'(bit_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
